// File: rtl/fft_arith_pkg.sv
// fft_arith_pkg: shared data/twiddle widths, Q1.7 unity constant, default multiplier latency
package fft_arith_pkg;
  localparam int DATA_WIDTH = 10;
  localparam int FACTOR_WIDTH = 9;
  localparam int MUL_WIDTH = DATA_WIDTH + FACTOR_WIDTH;
  localparam int TWIDDLE_ONE = 128;
  localparam int MUL_PIPE_STAGE_DEF = 1;
endpackage

// File: rtl/fft_arith_if.sv
// fft_arith_if: adder operands/result and multiplier operands/product/valid; master drives operands, slave returns results
interface fft_arith_if import fft_arith_pkg::*; #(
  parameter int ADD_A_WIDTH = DATA_WIDTH,
  parameter int ADD_B_WIDTH = DATA_WIDTH,
  parameter int ADD_OUT_WIDTH = DATA_WIDTH,
  parameter int MUL_A_WIDTH = DATA_WIDTH,
  parameter int MUL_B_WIDTH = FACTOR_WIDTH
);
  logic add_sub;
  logic signed [ADD_A_WIDTH-1:0] add_a;
  logic signed [ADD_B_WIDTH-1:0] add_b;
  logic signed [ADD_OUT_WIDTH-1:0] add_out;
  logic signed [MUL_A_WIDTH-1:0] mul_a;
  logic signed [MUL_B_WIDTH-1:0] mul_b;
  logic mul_vld_in;
  logic signed [MUL_A_WIDTH+MUL_B_WIDTH-1:0] mul_p;
  logic mul_vld_out;
  modport master (output add_sub, add_a, add_b, mul_a, mul_b, mul_vld_in, input add_out, mul_p, mul_vld_out);
  modport slave (input add_sub, add_a, add_b, mul_a, mul_b, mul_vld_in, output add_out, mul_p, mul_vld_out);
endinterface

// File: rtl/fft_arith_unit_addsub.sv
// addsub_comb: combinational signed a+b / a-b (sub), operands sign-extended or truncated to OUT_WIDTH, result wraps
module addsub_comb import fft_arith_pkg::*; #(
  parameter int A_WIDTH = DATA_WIDTH,
  parameter int B_WIDTH = DATA_WIDTH,
  parameter int OUT_WIDTH = DATA_WIDTH
) (
  input  logic sub,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  output logic signed [OUT_WIDTH-1:0] out
);
  logic signed [OUT_WIDTH-1:0] a_x, b_x;
  assign a_x = OUT_WIDTH'(a);
  assign b_x = OUT_WIDTH'(b);
  assign out = sub ? a_x - b_x : a_x + b_x;
endmodule

// File: rtl/fft_arith_unit.sv
// fft_arith_unit: comb add/sub plus MUL_PIPE_STAGE-deep signed multiplier with valid; ports clk, rst (async high), bus (fft_arith_if.slave)
module fft_arith_unit import fft_arith_pkg::*; #(
  parameter int ADD_A_WIDTH = DATA_WIDTH,
  parameter int ADD_B_WIDTH = DATA_WIDTH,
  parameter int ADD_OUT_WIDTH = DATA_WIDTH,
  parameter int MUL_A_WIDTH = DATA_WIDTH,
  parameter int MUL_B_WIDTH = FACTOR_WIDTH,
  parameter int MUL_PIPE_STAGE = MUL_PIPE_STAGE_DEF
) (
  input logic clk,
  input logic rst,
  fft_arith_if.slave bus
);
  localparam int P_WIDTH = MUL_A_WIDTH + MUL_B_WIDTH;
  logic signed [MUL_A_WIDTH-1:0] a_q;
  logic signed [MUL_B_WIDTH-1:0] b_q;
  logic vld_q;
  logic signed [P_WIDTH-1:0] prod;
  addsub_comb #(.A_WIDTH(ADD_A_WIDTH), .B_WIDTH(ADD_B_WIDTH), .OUT_WIDTH(ADD_OUT_WIDTH)) u_addsub (
    .sub(bus.add_sub), .a(bus.add_a), .b(bus.add_b), .out(bus.add_out)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q <= bus.mul_a;
      b_q <= bus.mul_b;
      vld_q <= bus.mul_vld_in;
    end
  end
  assign prod = P_WIDTH'(a_q) * P_WIDTH'(b_q);
  if (MUL_PIPE_STAGE == 1) begin : g_direct
    assign bus.mul_p = prod;
    assign bus.mul_vld_out = vld_q;
  end else begin : g_pipe
    logic signed [P_WIDTH-1:0] p_q [MUL_PIPE_STAGE-1];
    logic v_q [MUL_PIPE_STAGE-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < MUL_PIPE_STAGE-1; i++) begin
          p_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else begin
        p_q[0] <= prod;
        v_q[0] <= vld_q;
        for (int i = 1; i < MUL_PIPE_STAGE-1; i++) begin
          p_q[i] <= p_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end
    assign bus.mul_p = p_q[MUL_PIPE_STAGE-2];
    assign bus.mul_vld_out = v_q[MUL_PIPE_STAGE-2];
  end
endmodule

// File: tb/tb_fft_arith_unit.sv
// tb_fft_arith_unit: directed and random checks of fft_arith_unit at latency 1 and 3
module tb_fft_arith_unit;
  import fft_arith_pkg::*;
  logic clk, rst;
  int total, bad;
  fft_arith_if if1 ();
  fft_arith_if if3 ();
  fft_arith_unit dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  fft_arith_unit #(.MUL_PIPE_STAGE(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mul(input int a, input int b, input logic v);
    if1.mul_a = 10'(a); if1.mul_b = 9'(b); if1.mul_vld_in = v;
    if3.mul_a = 10'(a); if3.mul_b = 9'(b); if3.mul_vld_in = v;
  endtask

  task automatic set_add(input int a, input int b, input logic s);
    if1.add_a = 10'(a); if1.add_b = 10'(b); if1.add_sub = s;
    if3.add_a = 10'(a); if3.add_b = 10'(b); if3.add_sub = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_mul(0, 0, 1'b0);
    set_add(0, 0, 1'b0);
    tick; tick;
    total++; if (if1.mul_p !== 19'd0) begin bad++; $display("FAIL rst_p1 got=%0d want=0", if1.mul_p); end
    total++; if (if1.mul_vld_out !== 1'b0) begin bad++; $display("FAIL rst_v1 got=%b want=0", if1.mul_vld_out); end
    total++; if (if3.mul_p !== 19'd0) begin bad++; $display("FAIL rst_p3 got=%0d want=0", if3.mul_p); end
    total++; if (if3.mul_vld_out !== 1'b0) begin bad++; $display("FAIL rst_v3 got=%b want=0", if3.mul_vld_out); end
    rst = 1'b0;
    tick; tick; tick;
    total++; if (if3.mul_vld_out !== 1'b0) begin bad++; $display("FAIL rst_idle_v3 got=%b want=0", if3.mul_vld_out); end
  endtask

  task automatic test_adder;
    set_add(3, 5, 1'b0); #1;
    total++; if (if1.add_out !== 10'd8) begin bad++; $display("FAIL add_3p5 got=%h want=008", if1.add_out); end
    set_add(3, 5, 1'b1); #1;
    total++; if (if1.add_out !== 10'h3FE) begin bad++; $display("FAIL sub_3m5 got=%h want=3fe", if1.add_out); end
    set_add(511, 1, 1'b0); #1;
    total++; if (if1.add_out !== 10'h200) begin bad++; $display("FAIL add_wrap got=%h want=200", if1.add_out); end
    set_add(-512, 1, 1'b1); #1;
    total++; if (if1.add_out !== 10'h1FF) begin bad++; $display("FAIL sub_wrap got=%h want=1ff", if1.add_out); end
    set_add(-7, -9, 1'b0); #1;
    total++; if (if3.add_out !== 10'h3F0) begin bad++; $display("FAIL add_neg got=%h want=3f0", if3.add_out); end
  endtask

  task automatic test_latency;
    set_mul(100, TWIDDLE_ONE, 1'b1);
    tick;
    set_mul(0, 0, 1'b0);
    total++; if (if1.mul_p !== 19'd12800) begin bad++; $display("FAIL lat1_p got=%0d want=12800", if1.mul_p); end
    total++; if (if1.mul_vld_out !== 1'b1) begin bad++; $display("FAIL lat1_v got=%b want=1", if1.mul_vld_out); end
    total++; if (if3.mul_vld_out !== 1'b0) begin bad++; $display("FAIL lat3_early1 got=%b want=0", if3.mul_vld_out); end
    tick;
    total++; if (if1.mul_vld_out !== 1'b0) begin bad++; $display("FAIL lat1_once got=%b want=0", if1.mul_vld_out); end
    total++; if (if3.mul_vld_out !== 1'b0) begin bad++; $display("FAIL lat3_early2 got=%b want=0", if3.mul_vld_out); end
    tick;
    total++; if (if3.mul_p !== 19'd12800) begin bad++; $display("FAIL lat3_p got=%0d want=12800", if3.mul_p); end
    total++; if (if3.mul_vld_out !== 1'b1) begin bad++; $display("FAIL lat3_v got=%b want=1", if3.mul_vld_out); end
    tick;
    total++; if (if3.mul_vld_out !== 1'b0) begin bad++; $display("FAIL lat3_once got=%b want=0", if3.mul_vld_out); end
  endtask

  task automatic test_back_to_back;
    int va[4] = '{-512, 511, -1, 0};
    int vb[4] = '{-256, -256, 1, 127};
    int vp[4] = '{131072, -130816, -1, 0};
    set_mul(va[0], vb[0], 1'b1);
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (k < 4) set_mul(va[k], vb[k], 1'b1); else set_mul(0, 0, 1'b0);
      if (k <= 4) begin
        total++; if (if1.mul_p !== 19'(vp[k-1])) begin bad++; $display("FAIL b2b1_p[%0d] got=%0d want=%0d", k, if1.mul_p, vp[k-1]); end
        total++; if (if1.mul_vld_out !== 1'b1) begin bad++; $display("FAIL b2b1_v[%0d] got=%b want=1", k, if1.mul_vld_out); end
      end else begin
        total++; if (if1.mul_vld_out !== 1'b0) begin bad++; $display("FAIL b2b1_v[%0d] got=%b want=0", k, if1.mul_vld_out); end
      end
      if (k >= 3 && k <= 6) begin
        total++; if (if3.mul_p !== 19'(vp[k-3])) begin bad++; $display("FAIL b2b3_p[%0d] got=%0d want=%0d", k, if3.mul_p, vp[k-3]); end
        total++; if (if3.mul_vld_out !== 1'b1) begin bad++; $display("FAIL b2b3_v[%0d] got=%b want=1", k, if3.mul_vld_out); end
      end else begin
        total++; if (if3.mul_vld_out !== 1'b0) begin bad++; $display("FAIL b2b3_v[%0d] got=%b want=0", k, if3.mul_vld_out); end
      end
    end
  endtask

  task automatic test_reset_midflight;
    set_mul(7, 3, 1'b1);
    tick;
    set_mul(-8, 5, 1'b1);
    tick;
    set_mul(9, -2, 1'b1);
    tick;
    set_mul(0, 0, 1'b0);
    total++; if (if3.mul_p !== 19'd21 || if3.mul_vld_out !== 1'b1) begin bad++; $display("FAIL mid_before got=%0d/%b want=21/1", if3.mul_p, if3.mul_vld_out); end
    #2 rst = 1'b1;
    #1;
    total++; if (if3.mul_p !== 19'd0) begin bad++; $display("FAIL mid_p3 got=%0d want=0", if3.mul_p); end
    total++; if (if3.mul_vld_out !== 1'b0) begin bad++; $display("FAIL mid_v3 got=%b want=0", if3.mul_vld_out); end
    total++; if (if1.mul_p !== 19'd0) begin bad++; $display("FAIL mid_p1 got=%0d want=0", if1.mul_p); end
    total++; if (if1.mul_vld_out !== 1'b0) begin bad++; $display("FAIL mid_v1 got=%b want=0", if1.mul_vld_out); end
    tick; tick;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      total++; if (if3.mul_vld_out !== 1'b0) begin bad++; $display("FAIL stale_v3[%0d] got=%b want=0", k, if3.mul_vld_out); end
      total++; if (if1.mul_vld_out !== 1'b0) begin bad++; $display("FAIL stale_v1[%0d] got=%b want=0", k, if1.mul_vld_out); end
    end
  endtask

  task automatic test_random;
    int ph[4] = '{0, 0, 0, 0};
    logic vh[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic signed [9:0] ra, aa, ab;
    logic signed [8:0] rb;
    logic rv, rs;
    logic [9:0] ea;
    for (int n = 0; n < 10000; n++) begin
      ra = 10'($urandom); rb = 9'($urandom); rv = 1'($urandom);
      aa = 10'($urandom); ab = 10'($urandom); rs = 1'($urandom);
      set_mul(int'(ra), int'(rb), rv);
      set_add(int'(aa), int'(ab), rs);
      #1;
      ea = rs ? 10'(int'(aa) - int'(ab)) : 10'(int'(aa) + int'(ab));
      total++; if (if1.add_out !== ea) begin bad++; $display("FAIL rnd_add[%0d] got=%h want=%h", n, if1.add_out, ea); end
      tick;
      ph[3] = ph[2]; ph[2] = ph[1]; ph[1] = int'(ra) * int'(rb);
      vh[3] = vh[2]; vh[2] = vh[1]; vh[1] = rv;
      total++; if (if1.mul_p !== 19'(ph[1])) begin bad++; $display("FAIL rnd_p1[%0d] got=%0d want=%0d", n, if1.mul_p, ph[1]); end
      total++; if (if1.mul_vld_out !== vh[1]) begin bad++; $display("FAIL rnd_v1[%0d] got=%b want=%b", n, if1.mul_vld_out, vh[1]); end
      total++; if (if3.mul_p !== 19'(ph[3])) begin bad++; $display("FAIL rnd_p3[%0d] got=%0d want=%0d", n, if3.mul_p, ph[3]); end
      total++; if (if3.mul_vld_out !== vh[3]) begin bad++; $display("FAIL rnd_v3[%0d] got=%b want=%b", n, if3.mul_vld_out, vh[3]); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_adder;
    test_latency;
    test_back_to_back;
    test_reset_midflight;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
